// File: rtl/snake_pkg.sv
// Shared snake-game constants and the food placement state encoding.
`timescale 1ns/1ps
package snake_pkg;

  localparam int SCREEN_W = 240;
  localparam int SCREEN_H = 320;
  localparam int CELL     = 8;
  localparam int XW       = 8;
  localparam int YW       = 9;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    QUERY,
    WAIT
  } place_state_t;

endpackage

// File: rtl/food_placement_ctrl_if.sv
// Occupancy lookup channel between the food placer and the snake body map.
`timescale 1ns/1ps
interface food_placement_ctrl_if;
  import snake_pkg::*;

  logic          occ_req;
  logic [XW-1:0] occ_x;
  logic [YW-1:0] occ_y;
  logic          occ_valid;
  logic          occ_hit;

  modport master (
    output occ_req,
    output occ_x,
    output occ_y,
    input  occ_valid,
    input  occ_hit
  );

  modport slave (
    input  occ_req,
    input  occ_x,
    input  occ_y,
    output occ_valid,
    output occ_hit
  );

endinterface

// File: rtl/food_cell_snap.sv
// Snaps a pixel coordinate down to its cell origin and flags whether
// that cell lies fully inside the playfield.
`timescale 1ns/1ps
module food_cell_snap
  import snake_pkg::*;
#(
  parameter int W = SCREEN_W,
  parameter int H = SCREEN_H,
  parameter int C = CELL
) (
  input  logic [XW-1:0] rx,
  input  logic [YW-1:0] ry,
  output logic [XW-1:0] cx,
  output logic [YW-1:0] cy,
  output logic          in_bounds
);

  localparam logic [XW-1:0] XMASK = ~XW'(C - 1);
  localparam logic [YW-1:0] YMASK = ~YW'(C - 1);
  localparam logic [XW-1:0] XMAX  = XW'(W - C);
  localparam logic [YW-1:0] YMAX  = YW'(H - C);

  assign cx = rx & XMASK;
  assign cy = ry & YMASK;

  assign in_bounds = (cx <= XMAX) && (cy <= YMAX);

endmodule

// File: rtl/food_placement_ctrl.sv
// Food placement sequencer: sample, snap, bounds-check, occupancy query,
// retry until a free cell is found or the try budget runs out.
`timescale 1ns/1ps
module food_placement_ctrl
  import snake_pkg::*;
#(
  parameter int MAX_TRIES = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          place_req,
  input  logic          clear,
  input  logic [XW-1:0] randomX,
  input  logic [YW-1:0] randomY,
  food_placement_ctrl_if.master occ,
  output logic [XW-1:0] foodX,
  output logic [YW-1:0] foodY,
  output logic          food_valid,
  output logic          busy,
  output logic          placed,
  output logic          failed
);

  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam logic [TW-1:0] TMAX = TW'(MAX_TRIES);

  place_state_t  state;
  logic [TW-1:0] tries;
  logic [TW-1:0] tries_inc;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic          in_bounds;
  logic          occ_req_q;
  logic [XW-1:0] occ_x_q;
  logic [YW-1:0] occ_y_q;

  food_cell_snap u_snap (
    .rx        (randomX),
    .ry        (randomY),
    .cx        (cx),
    .cy        (cy),
    .in_bounds (in_bounds)
  );

  assign occ.occ_req = occ_req_q;
  assign occ.occ_x   = occ_x_q;
  assign occ.occ_y   = occ_y_q;

  // Saturating so a large budget can never wrap back to zero.
  assign tries_inc = (tries == TMAX) ? tries : tries + 1'b1;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      tries      <= '0;
      occ_req_q  <= 1'b0;
      occ_x_q    <= '0;
      occ_y_q    <= '0;
      foodX      <= '0;
      foodY      <= '0;
      food_valid <= 1'b0;
      busy       <= 1'b0;
      placed     <= 1'b0;
      failed     <= 1'b0;
    end else begin
      occ_req_q <= 1'b0;
      placed    <= 1'b0;
      failed    <= 1'b0;
      if (clear) begin
        state      <= IDLE;
        food_valid <= 1'b0;
        busy       <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (place_req) begin
              state      <= SAMPLE;
              busy       <= 1'b1;
              food_valid <= 1'b0;
              tries      <= '0;
            end
          end
          SAMPLE: begin
            if (in_bounds) begin
              occ_x_q <= cx;
              occ_y_q <= cy;
              state   <= QUERY;
            end else begin
              tries <= tries_inc;
              if (tries_inc == TMAX) begin
                failed     <= 1'b1;
                busy       <= 1'b0;
                food_valid <= 1'b0;
                state      <= IDLE;
              end
            end
          end
          QUERY: begin
            occ_req_q <= 1'b1;
            state     <= WAIT;
          end
          WAIT: begin
            if (occ.occ_valid) begin
              if (!occ.occ_hit) begin
                foodX      <= occ_x_q;
                foodY      <= occ_y_q;
                food_valid <= 1'b1;
                placed     <= 1'b1;
                busy       <= 1'b0;
                state      <= IDLE;
              end else begin
                tries <= tries_inc;
                if (tries_inc == TMAX) begin
                  failed     <= 1'b1;
                  busy       <= 1'b0;
                  food_valid <= 1'b0;
                  state      <= IDLE;
                end else begin
                  state <= SAMPLE;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_food_placement_ctrl.sv
// Directed bench for food_placement_ctrl with a registered occupancy
// responder that answers one cycle after each query strobe.
`timescale 1ns/1ps
module tb_food_placement_ctrl;
  import snake_pkg::*;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          place_req = 1'b0;
  logic          clear = 1'b0;
  logic [XW-1:0] randomX = '0;
  logic [YW-1:0] randomY = '0;
  logic [XW-1:0] foodX;
  logic [YW-1:0] foodY;
  logic          food_valid;
  logic          busy;
  logic          placed;
  logic          failed;

  always #5 clock = ~clock;

  food_placement_ctrl_if ifc ();

  food_placement_ctrl #(.MAX_TRIES(16)) dut (
    .clock      (clock),
    .reset      (reset),
    .place_req  (place_req),
    .clear      (clear),
    .randomX    (randomX),
    .randomY    (randomY),
    .occ        (ifc.master),
    .foodX      (foodX),
    .foodY      (foodY),
    .food_valid (food_valid),
    .busy       (busy),
    .placed     (placed),
    .failed     (failed)
  );

  int nchk = 0;
  int nerr = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask

  bit rsp_on;
  bit hit_dflt;
  bit hits[$];
  int rx_q[$];
  int nreq, nplaced, nfailed, ncyc, placed_at, bad248;
  int lastx, lasty;

  task automatic clr_stats();
    nreq = 0; nplaced = 0; nfailed = 0;
    ncyc = 0; placed_at = 0; bad248 = 0;
    lastx = -1; lasty = -1;
  endtask

  // One clock: responder reacts to the strobe seen in the previous cycle.
  task automatic cyc();
    logic seen;
    seen = ifc.occ_req;
    @(posedge clock);
    #1;
    ncyc++;
    place_req = 1'b0;
    ifc.occ_valid = 1'b0;
    if (seen && rsp_on) begin
      ifc.occ_valid = 1'b1;
      ifc.occ_hit = (hits.size() > 0) ? hits.pop_front() : hit_dflt;
    end
    if (rx_q.size() > 0) randomX = XW'(rx_q.pop_front());
    if (ifc.occ_req) begin
      nreq++;
      lastx = int'(ifc.occ_x);
      lasty = int'(ifc.occ_y);
      if (ifc.occ_x == 8'd248) bad248++;
    end
    if (placed) begin
      nplaced++;
      placed_at = ncyc;
    end
    if (failed) nfailed++;
  endtask

  task automatic start();
    clr_stats();
    place_req = 1'b1;
    cyc();
  endtask

  task automatic run(string tag, int maxc);
    int k;
    k = 0;
    while (busy && k < maxc) begin
      cyc();
      k++;
    end
    chk(tag, 32'(busy), 0);
  endtask

  task automatic wait_req(string tag);
    for (int k = 0; k < 20 && nreq == 0; k++) cyc();
    chk(tag, nreq, 1);
  endtask

  initial begin
    ifc.occ_valid = 1'b0;
    ifc.occ_hit = 1'b0;
    rsp_on = 1'b1;
    hit_dflt = 1'b0;
    clr_stats();

    #12;
    chk("rst_flags", {busy, food_valid, placed, failed, ifc.occ_req}, 0);
    chk("rst_food", {foodX, foodY}, 0);
    @(negedge clock);
    reset = 1'b1;

    // clean placement
    randomX = 8'd37; randomY = 9'd100;
    hits = '{1'b0};
    start();
    run("clean_done", 20);
    chk("clean_qx", lastx, 32);
    chk("clean_qy", lasty, 96);
    chk("clean_fx", foodX, 32);
    chk("clean_fy", foodY, 96);
    chk("clean_fv", food_valid, 1);
    chk("clean_lat", placed_at - 1, 4);
    chk("clean_np", nplaced, 1);
    cyc();
    chk("clean_pw", placed, 0);

    // out-of-bounds sample consumes one try
    randomX = 8'd250;
    rx_q = '{250, 17};
    hits = '{1'b0};
    start();
    run("oob_done", 20);
    chk("oob_nreq", nreq, 1);
    chk("oob_248", bad248, 0);
    chk("oob_qx", lastx, 16);
    chk("oob_fx", foodX, 16);
    chk("oob_lat", placed_at - 1, 5);

    // two collisions then a free cell
    randomX = 8'd37; randomY = 9'd100;
    hits = '{1'b1, 1'b1, 1'b0};
    start();
    run("coll_done", 40);
    chk("coll_nreq", nreq, 3);
    chk("coll_np", nplaced, 1);
    chk("coll_nf", nfailed, 0);
    chk("coll_fx", foodX, 32);

    // exhaustion keeps previous food coordinates
    randomX = 8'd64; randomY = 9'd128;
    hits = '{1'b0};
    start();
    run("pre_done", 20);
    chk("pre_fx", foodX, 64);
    hit_dflt = 1'b1;
    start();
    run("exh_done", 200);
    chk("exh_nreq", nreq, 16);
    chk("exh_nf", nfailed, 1);
    chk("exh_np", nplaced, 0);
    chk("exh_fv", food_valid, 0);
    chk("exh_fx", foodX, 64);
    chk("exh_fy", foodY, 128);
    cyc();
    chk("exh_pw", failed, 0);

    // clear while waiting, then a late response
    hit_dflt = 1'b0;
    rsp_on = 1'b0;
    randomX = 8'd37; randomY = 9'd100;
    start();
    wait_req("abt_req");
    cyc();
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("abt_busy", busy, 0);
    chk("abt_fv", food_valid, 0);
    ifc.occ_valid = 1'b1;
    ifc.occ_hit = 1'b0;
    cyc();
    cyc();
    chk("late_np", nplaced, 0);
    chk("late_fv", food_valid, 0);
    chk("late_busy", busy, 0);

    // request while busy is dropped
    rsp_on = 1'b1;
    hits = '{1'b0};
    start();
    cyc();
    place_req = 1'b1;
    cyc();
    run("ovl_done", 20);
    for (int k = 0; k < 8; k++) cyc();
    chk("ovl_np", nplaced, 1);
    chk("ovl_nreq", nreq, 1);
    chk("ovl_busy", busy, 0);

    // async reset in WAIT
    rsp_on = 1'b0;
    randomX = 8'd64; randomY = 9'd128;
    start();
    wait_req("rst_req");
    #3;
    reset = 1'b0;
    #1;
    chk("arst_flags", {busy, food_valid, placed, failed, ifc.occ_req}, 0);
    chk("arst_food", {foodX, foodY}, 0);
    chk("arst_occ", {ifc.occ_x, ifc.occ_y}, 0);
    @(negedge clock);
    reset = 1'b1;
    ifc.occ_valid = 1'b1;
    ifc.occ_hit = 1'b0;
    cyc();
    cyc();
    chk("arst_np", nplaced, 0);
    chk("arst_fv", food_valid, 0);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

endmodule
